busca_instrucao: RTL and testbench
==================================

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 Parameter LARGURA, default 32: width of addresses and instruction words.
REQ-002 Parameter MAX_ESPERA, default 15: number of cycles without mem_ack that counts as a timeout (range 1..255).
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; block held in reset while high.
REQ-005 endereco_atual  in  LARGURA  current address from the program counter.
REQ-006 halt_pc  out  1  high freezes the program counter; low for one cycle lets it load its next address.
REQ-007 consumidor_pronto  in  1  decode stage accepts instrucao this cycle.
REQ-008 flush  in  1  branch/jump taken; discard any fetch in progress.
REQ-009 instrucao  out  LARGURA  fetched instruction word.
REQ-010 instrucao_valida  out  1  instrucao holds a valid undelivered word.
REQ-011 mem_req  out  1  request to instruction memory.
REQ-012 mem_endereco  out  LARGURA  request address.
REQ-013 mem_ack  in  1  memory returns mem_dado this cycle.
REQ-014 mem_dado  in  LARGURA  instruction word from memory.
REQ-015 erro_busca  out  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have the states OCIOSO, REQUISITA, DESCARTE, ENTREGA and ERRO.
REQ-017 OCIOSO SHALL go to REQUISITA unconditionally on the next edge.
REQ-018 In REQUISITA: mem_req=1; mem_endereco=endereco_atual; endereco_reg loaded each cycle from endereco_atual.
REQ-019 Once raised, mem_req SHALL stay high with a stable mem_endereco until mem_ack is sampled; a request is never withdrawn.
REQ-020 REQUISITA with mem_ack and no flush SHALL capture mem_dado into instrucao, set instrucao_valida and go to ENTREGA; mem_ack in the first REQUISITA cycle is legal (1-cycle fetch).
REQ-021 REQUISITA with flush and no mem_ack SHALL go to DESCARTE.
REQ-022 REQUISITA with flush and mem_ack in the same cycle SHALL drop the data and re-enter REQUISITA.
REQ-023 In DESCARTE: mem_req=1; mem_endereco=endereco_reg (the old address). On mem_ack the data is dropped and the FSM goes to REQUISITA. Further flushes are ignored.
REQ-024 In ENTREGA: mem_req=0; instrucao is held stable.
REQ-025 ENTREGA with consumidor_pronto SHALL clear instrucao_valida on the next edge and go to REQUISITA.
REQ-026 flush in ENTREGA SHALL have priority over consumidor_pronto: the word counts as not transferred, valid clears and the FSM goes to REQUISITA.
REQ-027 halt_pc SHALL be 0 only in a cycle where (ENTREGA and (consumidor_pronto or flush)) or (REQUISITA and flush); otherwise halt_pc=1.
REQ-028 As a result of REQ-027, the PC advances exactly once per delivered or flushed instruction.
REQ-029 A wait counter SHALL clear on entry to REQUISITA or DESCARTE and increment each cycle in which mem_ack=0.
REQ-030 When the wait counter reaches MAX_ESPERA, the FSM SHALL go to ERRO.
REQ-031 In ERRO: erro_busca=1, mem_req=0, halt_pc=1, instrucao_valida=0. flush, consumidor_pronto and mem_ack are ignored. ERRO is exited only by reset.
REQ-032 The counter width SHALL be clog2(MAX_ESPERA+1) bits and SHALL saturate, never wrap.
REQ-033 mem_ack outside REQUISITA/DESCARTE SHALL be ignored.

Reset
REQ-034 On reset: state=OCIOSO; mem_req=0; instrucao=0; instrucao_valida=0; erro_busca=0; halt_pc=1; counter=0; endereco_reg=0.
REQ-035 Reset asserted mid-request SHALL drop mem_req asynchronously; memory-side cleanup is the system's responsibility.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the default LARGURA/MAX_ESPERA constants and the counter-width function.
REQ-037 The wait counter SHALL be a sub-module named contador_espera, with clear, enable and saturating-limit ports.

Verification
REQ-038 Reset, then 1-cycle memory (mem_ack with mem_req), consumidor_pronto=1 -> instructions at addresses 0,4,8 delivered on alternate cycles; halt_pc pulses low once per word.
REQ-039 mem_ack delayed 3 cycles, mem_dado=0xDEADBEEF -> mem_req high 3 cycles with a constant address; instrucao=0xDEADBEEF, valid=1 on the following cycle.
REQ-040 consumidor_pronto=0 for 5 cycles in ENTREGA -> instrucao stable, valid=1, halt_pc=1 throughout; no new mem_req.
REQ-041 flush in the 2nd waiting cycle at address 0x10, PC loads 0x40, ack 2 cycles later -> mem_endereco stays 0x10 until ack; data dropped; next request at 0x40; no valid pulse for 0x10.
REQ-042 flush and mem_ack in the same cycle; separately, flush with consumidor_pronto in ENTREGA -> both dropped, valid=0, single halt_pc low pulse each.
REQ-043 MAX_ESPERA=15, mem_ack never asserted -> erro_busca=1 after 15 waiting cycles, mem_req=0; async reset mid-wait clears all outputs immediately.

Source files
------------

// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, default
// sizes and the width helper for the wait counter.
package busca_instrucao_pkg;

    localparam int LARGURA_PADRAO    = 32;
    localparam int MAX_ESPERA_PADRAO = 15;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        REQUISITA = 3'd1,
        DESCARTE  = 3'd2,
        ENTREGA   = 3'd3,
        ERRO      = 3'd4
    } estado_t;

    // Bits needed to hold every value from 0 up to max_espera inclusive.
    function automatic int largura_contador(input int max_espera);
        return $clog2(max_espera + 1);
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Saturating wait counter: synchronous clear has priority over enable, and
// counting stops once the limit is reached.
module contador_espera #(
    parameter int LARGURA_CONT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    limpar,
    input  logic                    habilitar,
    input  logic [LARGURA_CONT-1:0] limite,
    output logic [LARGURA_CONT-1:0] contagem,
    output logic                    no_limite
);

    assign no_limite = (contagem >= limite);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (limpar) begin
            contagem <= '0;
        end else if (habilitar && !no_limite) begin
            contagem <= contagem + 1'b1;
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: issues memory requests for the PC address, hands the
// word to decode, drops fetches killed by flush and traps on memory timeout.
//
// Handshakes: a memory request (mem_req) is held with a stable address until
// mem_ack is sampled high and is never withdrawn; the delivered word transfers
// in a cycle where instrucao_valida and consumidor_pronto are both high and
// flush is low.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int MAX_ESPERA = MAX_ESPERA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] endereco_atual,
    output logic               halt_pc,
    input  logic               consumidor_pronto,
    input  logic               flush,
    output logic [LARGURA-1:0] instrucao,
    output logic               instrucao_valida,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_endereco,
    input  logic               mem_ack,
    input  logic [LARGURA-1:0] mem_dado,
    output logic               erro_busca,
    output estado_t            estado_dbg
);

    localparam int                    LARG_CONT   = largura_contador(MAX_ESPERA);
    localparam logic [LARG_CONT-1:0] LIMITE      = LARG_CONT'(MAX_ESPERA);
    localparam logic [LARG_CONT-1:0] ULTIMA_ESPERA = LARG_CONT'(MAX_ESPERA - 1);

    estado_t                estado;
    estado_t                estado_prox;
    logic [LARGURA-1:0]     endereco_reg;
    logic [LARG_CONT-1:0]   contagem;
    logic                   no_limite;
    logic                   limpar_cont;
    logic                   habilitar_cont;
    logic                   capturar;
    logic                   liberar;

    assign estado_dbg = estado;

    contador_espera #(
        .LARGURA_CONT (LARG_CONT)
    ) u_contador_espera (
        .clock     (clock),
        .reset     (reset),
        .limpar    (limpar_cont),
        .habilitar (habilitar_cont),
        .limite    (LIMITE),
        .contagem  (contagem),
        .no_limite (no_limite)
    );

    // Only cycles spent waiting on memory count toward the timeout.
    assign habilitar_cont = mem_req && !mem_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox  = estado;
        limpar_cont  = 1'b0;
        capturar     = 1'b0;
        liberar      = 1'b0;
        halt_pc      = 1'b1;
        mem_req      = 1'b0;
        mem_endereco = endereco_reg;
        erro_busca   = 1'b0;
        case (estado)
            OCIOSO: begin
                estado_prox = REQUISITA;
                limpar_cont = 1'b1;
            end
            REQUISITA: begin
                mem_req      = 1'b1;
                mem_endereco = endereco_atual;
                if (flush) begin
                    // Let the PC take the branch target; an ack in this same
                    // cycle means the old request is already finished.
                    halt_pc     = 1'b0;
                    limpar_cont = 1'b1;
                    estado_prox = mem_ack ? REQUISITA : DESCARTE;
                end else if (mem_ack) begin
                    capturar    = 1'b1;
                    estado_prox = ENTREGA;
                end else if (contagem == ULTIMA_ESPERA || no_limite) begin
                    estado_prox = ERRO;
                end
            end
            DESCARTE: begin
                // Keep the abandoned request alive on the old address until acked.
                mem_req = 1'b1;
                if (mem_ack) begin
                    limpar_cont = 1'b1;
                    estado_prox = REQUISITA;
                end else if (contagem == ULTIMA_ESPERA || no_limite) begin
                    estado_prox = ERRO;
                end
            end
            ENTREGA: begin
                if (flush || consumidor_pronto) begin
                    halt_pc     = 1'b0;
                    liberar     = 1'b1;
                    limpar_cont = 1'b1;
                    estado_prox = REQUISITA;
                end
            end
            ERRO: begin
                erro_busca = 1'b1;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco_reg     <= '0;
            instrucao        <= '0;
            instrucao_valida <= 1'b0;
        end else begin
            if (estado == REQUISITA) begin
                endereco_reg <= endereco_atual;
            end
            if (capturar) begin
                instrucao <= mem_dado;
            end
            if (capturar) begin
                instrucao_valida <= 1'b1;
            end else if (liberar || estado == ERRO) begin
                instrucao_valida <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: inputs change 1 time unit after the
// rising edge and outputs are checked 3 time units later, before the falling edge.
module tb_busca_instrucao;
    import busca_instrucao_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] endereco_atual;
    logic        halt_pc;
    logic        consumidor_pronto;
    logic        flush;
    logic [31:0] instrucao;
    logic        instrucao_valida;
    logic        mem_req;
    logic [31:0] mem_endereco;
    logic        mem_ack;
    logic [31:0] mem_dado;
    logic        erro_busca;
    estado_t     estado_dbg;

    int testes;
    int falhas;

    busca_instrucao #(
        .LARGURA    (32),
        .MAX_ESPERA (15)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .endereco_atual    (endereco_atual),
        .halt_pc           (halt_pc),
        .consumidor_pronto (consumidor_pronto),
        .flush             (flush),
        .instrucao         (instrucao),
        .instrucao_valida  (instrucao_valida),
        .mem_req           (mem_req),
        .mem_endereco      (mem_endereco),
        .mem_ack           (mem_ack),
        .mem_dado          (mem_dado),
        .erro_busca        (erro_busca),
        .estado_dbg        (estado_dbg)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        testes++;
        assert (obs === esp) else begin
            falhas++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic amostra();
        #3;
    endtask

    initial begin
        testes            = 0;
        falhas            = 0;
        reset             = 1'b1;
        endereco_atual    = '0;
        consumidor_pronto = 1'b0;
        flush             = 1'b0;
        mem_ack           = 1'b0;
        mem_dado          = '0;

        // Reset values
        repeat (2) @(posedge clock);
        #4;
        verifica("rst_mem_req", {31'd0, mem_req}, 32'd0);
        verifica("rst_instrucao", instrucao, 32'd0);
        verifica("rst_valida", {31'd0, instrucao_valida}, 32'd0);
        verifica("rst_erro", {31'd0, erro_busca}, 32'd0);
        verifica("rst_halt", {31'd0, halt_pc}, 32'd1);

        // 1-cycle memory, consumer always ready: words at 0, 4, 8
        ciclo(); reset = 1'b0; consumidor_pronto = 1'b1; endereco_atual = 32'h0;
        amostra();
        verifica("ocioso_mem_req", {31'd0, mem_req}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            ciclo(); endereco_atual = 32'(i * 4); mem_ack = 1'b1; mem_dado = 32'h1000_0000 + 32'(i * 4);
            amostra();
            verifica("rapida_mem_req", {31'd0, mem_req}, 32'd1);
            verifica("rapida_endereco", mem_endereco, 32'(i * 4));
            verifica("rapida_halt_req", {31'd0, halt_pc}, 32'd1);
            ciclo(); mem_ack = 1'b0;
            amostra();
            verifica("rapida_valida", {31'd0, instrucao_valida}, 32'd1);
            verifica("rapida_instrucao", instrucao, 32'h1000_0000 + 32'(i * 4));
            verifica("rapida_halt_pulso", {31'd0, halt_pc}, 32'd0);
            verifica("rapida_sem_req", {31'd0, mem_req}, 32'd0);
        end

        // Ack on the 3rd request cycle with 0xDEADBEEF
        ciclo(); endereco_atual = 32'hC; consumidor_pronto = 1'b0; mem_ack = 1'b0;
        amostra();
        verifica("lenta_req1", {31'd0, mem_req}, 32'd1);
        verifica("lenta_end1", mem_endereco, 32'hC);
        verifica("lenta_halt1", {31'd0, halt_pc}, 32'd1);
        ciclo();
        amostra();
        verifica("lenta_req2", {31'd0, mem_req}, 32'd1);
        verifica("lenta_end2", mem_endereco, 32'hC);
        ciclo(); mem_ack = 1'b1; mem_dado = 32'hDEAD_BEEF;
        amostra();
        verifica("lenta_req3", {31'd0, mem_req}, 32'd1);
        verifica("lenta_end3", mem_endereco, 32'hC);

        // Consumer stalls 5 cycles; stray acks must be ignored
        for (int i = 0; i < 5; i++) begin
            ciclo(); mem_ack = 1'b1; mem_dado = 32'h5555_5555;
            amostra();
            verifica("parado_instrucao", instrucao, 32'hDEAD_BEEF);
            verifica("parado_valida", {31'd0, instrucao_valida}, 32'd1);
            verifica("parado_halt", {31'd0, halt_pc}, 32'd1);
            verifica("parado_sem_req", {31'd0, mem_req}, 32'd0);
        end
        ciclo(); mem_ack = 1'b0; consumidor_pronto = 1'b1;
        amostra();
        verifica("parado_entrega_halt", {31'd0, halt_pc}, 32'd0);
        verifica("parado_entrega_valida", {31'd0, instrucao_valida}, 32'd1);

        // Flush in 2nd waiting cycle at 0x10, PC moves to 0x40, ack 2 cycles later
        ciclo(); endereco_atual = 32'h10;
        amostra();
        verifica("flush_req_end", mem_endereco, 32'h10);
        ciclo(); flush = 1'b1;
        amostra();
        verifica("flush_halt", {31'd0, halt_pc}, 32'd0);
        verifica("flush_end", mem_endereco, 32'h10);
        ciclo(); endereco_atual = 32'h40; flush = 1'b1;
        amostra();
        verifica("descarte_req", {31'd0, mem_req}, 32'd1);
        verifica("descarte_end", mem_endereco, 32'h10);
        verifica("descarte_flush_ignorado", {31'd0, halt_pc}, 32'd1);
        ciclo(); flush = 1'b0; mem_ack = 1'b1; mem_dado = 32'hBAD0_BAD0;
        amostra();
        verifica("descarte_end_ack", mem_endereco, 32'h10);
        verifica("descarte_valida", {31'd0, instrucao_valida}, 32'd0);
        ciclo(); mem_ack = 1'b1; mem_dado = 32'h4040_4040;
        amostra();
        verifica("pos_descarte_end", mem_endereco, 32'h40);
        verifica("pos_descarte_valida", {31'd0, instrucao_valida}, 32'd0);
        verifica("pos_descarte_req", {31'd0, mem_req}, 32'd1);
        ciclo(); mem_ack = 1'b0;
        amostra();
        verifica("pos_descarte_instrucao", instrucao, 32'h4040_4040);
        verifica("pos_descarte_entrega", {31'd0, instrucao_valida}, 32'd1);

        // Flush together with ack: data dropped, single halt pulse
        ciclo(); endereco_atual = 32'h44; flush = 1'b1; mem_ack = 1'b1; mem_dado = 32'h1111_1111;
        amostra();
        verifica("flush_ack_halt", {31'd0, halt_pc}, 32'd0);
        verifica("flush_ack_end", mem_endereco, 32'h44);
        ciclo(); endereco_atual = 32'h80; flush = 1'b0; mem_ack = 1'b1; mem_dado = 32'h2222_2222;
        amostra();
        verifica("flush_ack_valida", {31'd0, instrucao_valida}, 32'd0);
        verifica("flush_ack_halt_alto", {31'd0, halt_pc}, 32'd1);
        verifica("flush_ack_novo_end", mem_endereco, 32'h80);

        // Flush with consumer ready in ENTREGA
        ciclo(); mem_ack = 1'b0; flush = 1'b1; consumidor_pronto = 1'b1;
        amostra();
        verifica("flush_entrega_instrucao", instrucao, 32'h2222_2222);
        verifica("flush_entrega_halt", {31'd0, halt_pc}, 32'd0);
        ciclo(); flush = 1'b0; consumidor_pronto = 1'b0; endereco_atual = 32'hC0;
        amostra();
        verifica("flush_entrega_valida", {31'd0, instrucao_valida}, 32'd0);
        verifica("flush_entrega_halt_alto", {31'd0, halt_pc}, 32'd1);
        verifica("timeout_req_inicio", {31'd0, mem_req}, 32'd1);

        // Memory never answers: 15 waiting cycles then ERRO
        for (int i = 0; i < 14; i++) begin
            ciclo();
            amostra();
            verifica("timeout_espera_req", {31'd0, mem_req}, 32'd1);
            verifica("timeout_espera_erro", {31'd0, erro_busca}, 32'd0);
        end
        ciclo();
        amostra();
        verifica("timeout_erro", {31'd0, erro_busca}, 32'd1);
        verifica("timeout_sem_req", {31'd0, mem_req}, 32'd0);
        verifica("timeout_halt", {31'd0, halt_pc}, 32'd1);
        verifica("timeout_valida", {31'd0, instrucao_valida}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            ciclo(); flush = 1'b1; consumidor_pronto = 1'b1; mem_ack = 1'b1;
            amostra();
            verifica("erro_preso", {31'd0, erro_busca}, 32'd1);
            verifica("erro_halt", {31'd0, halt_pc}, 32'd1);
            verifica("erro_sem_req", {31'd0, mem_req}, 32'd0);
        end

        // Reset leaves ERRO
        reset = 1'b1;
        #1;
        verifica("erro_reset_erro", {31'd0, erro_busca}, 32'd0);
        verifica("erro_reset_halt", {31'd0, halt_pc}, 32'd1);
        ciclo(); reset = 1'b0; flush = 1'b0; consumidor_pronto = 1'b0; mem_ack = 1'b0;
        endereco_atual = 32'h100;
        ciclo();
        amostra();
        verifica("reinicio_req", {31'd0, mem_req}, 32'd1);
        ciclo();
        amostra();
        verifica("reinicio_req_espera", {31'd0, mem_req}, 32'd1);

        // Asynchronous reset in the middle of a wait
        #1 reset = 1'b1;
        #1;
        verifica("async_mem_req", {31'd0, mem_req}, 32'd0);
        verifica("async_valida", {31'd0, instrucao_valida}, 32'd0);
        verifica("async_instrucao", instrucao, 32'd0);
        verifica("async_erro", {31'd0, erro_busca}, 32'd0);
        verifica("async_halt", {31'd0, halt_pc}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
